// File: rtl/ucode_pkg.sv
// ucode_pkg: control-word bit map, opcode map and defaults shared by the microprogram sequencer
package ucode_pkg;

    localparam int CW_DEF    = 22;
    localparam int AW_DEF    = 7;
    localparam int SLOTS_DEF = 4;
    localparam int OPW_DEF   = 4;

    localparam int BIT_ADD      = 0;
    localparam int BIT_SUB      = 1;
    localparam int BIT_AND      = 2;
    localparam int BIT_OR       = 3;
    localparam int BIT_XOR      = 4;
    localparam int BIT_PC_OUT   = 5;
    localparam int BIT_MAR_IN   = 6;
    localparam int BIT_READ     = 7;
    localparam int BIT_WMFC     = 8;
    localparam int BIT_MDR_OUT  = 9;
    localparam int BIT_IR_IN    = 10;
    localparam int BIT_PC_INC   = 11;
    localparam int BIT_R_IN     = 12;
    localparam int BIT_R_OUT    = 13;
    localparam int BIT_Y_IN     = 14;
    localparam int BIT_Z_OUT    = 15;
    localparam int BIT_DISP     = 16;
    localparam int BIT_WRITE    = 17;
    localparam int BIT_Z_IN     = 18;
    localparam int BIT_MDR_IN   = 19;
    localparam int BIT_FLAG_OUT = 20;
    localparam int BIT_END      = CW_DEF - 1;

    typedef enum logic [OPW_DEF-1:0] {
        OP_FETCH, OP_LOAD, OP_STORE, OP_MOVE_RR, OP_MOVE_RI, OP_SUM_RR, OP_SUM_RI, OP_SUB_RR,
        OP_SUB_RI, OP_AND_RR, OP_AND_RI, OP_OR_RR, OP_OR_RI, OP_XOR_RR, OP_XOR_RI, OP_NOP
    } opcode_e;

endpackage

// File: rtl/control_store_ram.sv
// control_store_ram: writable control store, synchronous write and asynchronous read
module control_store_ram
    import ucode_pkg::*;
#(
    parameter int    CW        = CW_DEF,
    parameter int    AW        = AW_DEF,
    parameter int    DEPTH     = 128,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [CW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [CW-1:0] rd_data
);

    localparam int PW = AW + 1;

    logic [CW-1:0] mem [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    always @(posedge clk) begin
        if (wr_en && {1'b0, wr_addr} < PW'(DEPTH)) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: control store with CAR/CBR and next-address logic, one control word per cycle
module micro_sequencer
    import ucode_pkg::*;
#(
    parameter int    CW        = CW_DEF,
    parameter int    AW        = AW_DEF,
    parameter int    DEPTH     = 128,
    parameter int    SLOTS     = SLOTS_DEF,
    parameter int    OPW       = OPW_DEF,
    parameter int    WMFC_BIT  = BIT_WMFC,
    parameter int    DISP_BIT  = BIT_DISP,
    parameter int    END_BIT   = CW - 1,
    parameter string INIT_FILE = ""
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_done,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [CW-1:0]  wr_data,
    output logic [AW-1:0]  car,
    output logic [CW-1:0]  cbr,
    output logic           cw_valid,
    output logic           stall,
    output logic           illegal
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam int         PW   = AW + 1;

    logic [0:0]    state;
    logic [AW-1:0] nxt;
    logic [CW-1:0] rd_data;
    logic [PW-1:0] disp;
    logic          running, ends, load, ill_c;

    assign running = state == RUN;
    assign disp    = PW'(opcode) * PW'(SLOTS);
    assign stall   = running && cbr[WMFC_BIT] && !mem_done;
    assign ends    = running && !stall && cbr[END_BIT] && !run;
    assign load    = running ? !stall && !ends : run;

    // next address: END and IDLE return to fetch base, dispatch jumps to the opcode slot, else increment
    always_comb begin
        nxt   = '0;
        ill_c = 1'b0;
        if (running && !cbr[END_BIT] && cbr[DISP_BIT]) begin
            ill_c = disp >= PW'(DEPTH);
            nxt   = ill_c ? '0 : disp[AW-1:0];
        end else if (running && !cbr[END_BIT]) begin
            ill_c = car == AW'(DEPTH - 1);
            nxt   = ill_c ? '0 : car + AW'(1);
        end
    end

    // CAR/CBR update with write-through bypass so a same-cycle write to the next word is seen
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            car      <= '0;
            cbr      <= '0;
            cw_valid <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            illegal <= load && ill_c;
            if (ends) begin
                state    <= IDLE;
                car      <= '0;
                cbr      <= '0;
                cw_valid <= 1'b0;
            end else if (load) begin
                state    <= RUN;
                car      <= nxt;
                cbr      <= (wr_en && wr_addr == nxt) ? wr_data : rd_data;
                cw_valid <= 1'b1;
            end
        end
    end

    control_store_ram #(
        .CW(CW), .AW(AW), .DEPTH(DEPTH), .INIT_FILE(INIT_FILE)
    ) u_store (
        .clk(clk), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(nxt), .rd_data(rd_data)
    );

endmodule
